// File: rtl/uart_rx_mem_writer.sv
// Packs received UART bytes little-endian into 32-bit words and writes them to on-chip memory.
// Build option: define UART_RX_MEM_WRAP_EN to wrap wr_ptr at DEPTH instead of stopping in FULL.
module uart_rx_mem_writer #(
    parameter int DEPTH  = 40000,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              clr,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              full,
    output logic              dbg_state,
    output logic [1:0]        dbg_lane
);

    // Handshake: a byte transfers on a rising clk edge where in_valid and in_ready are both
    // high; in_valid may rise independently of in_ready and in_data must be stable while it is high.

    typedef enum logic {S_ACC = 1'b0, S_FULL = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic              up_q;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       pack_q, pack_d;
    logic              pend_q, pend_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        be_q, be_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              accept;
    logic              write_now;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_ACC;
            up_q    <= 1'b0;
            lane_q  <= 2'd0;
            pack_q  <= 24'd0;
            pend_q  <= 1'b0;
            data_q  <= 32'd0;
            be_q    <= 4'd0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            up_q    <= 1'b1;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            be_q    <= be_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        pack_d    = pack_q;
        pend_d    = 1'b0;
        data_d    = data_q;
        be_d      = be_q;
        ptr_d     = ptr_q;
        in_ready  = up_q && (state_q == S_ACC) && !clr;
        accept    = in_valid && in_ready;
        write_now = pend_q && (state_q == S_ACC) && !clr;

        if (write_now) begin
            if (ptr_q == LAST_ADDR) begin
`ifdef UART_RX_MEM_WRAP_EN
                ptr_d = '0;
`else
                state_d = S_FULL;
`endif
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end

        if (accept) begin
            if (lane_q == 2'd3) begin
                data_d = {in_data, pack_q};
                be_d   = 4'b1111;
                pend_d = 1'b1;
                lane_d = 2'd0;
                pack_d = 24'd0;
            end else begin
                pack_d[{lane_q, 3'b000} +: 8] = in_data;
                lane_d = lane_q + 2'd1;
            end
        end

        // Flush looks at the lane count after this cycle's byte, so a byte that completes
        // the word leaves lane_d at zero and the flush does nothing.
        if (flush && (state_q == S_ACC) && (lane_d != 2'd0)) begin
            data_d = {8'h00, pack_d};
            pend_d = 1'b1;
            case (lane_d)
                2'd1:    be_d = 4'b0001;
                2'd2:    be_d = 4'b0011;
                default: be_d = 4'b0111;
            endcase
            lane_d = 2'd0;
            pack_d = 24'd0;
        end

        if (clr) begin
            state_d = S_ACC;
            lane_d  = 2'd0;
            pack_d  = 24'd0;
            pend_d  = 1'b0;
            ptr_d   = '0;
        end
    end

    assign mem_write      = write_now;
    assign mem_chipselect = write_now;
    assign mem_writedata  = write_now ? data_q : 32'd0;
    assign mem_byteenable = write_now ? be_q : 4'd0;
    assign mem_address    = ptr_q;
    assign wr_ptr         = ptr_q;
    assign full           = (state_q == S_FULL);
    assign dbg_state      = state_q;
    assign dbg_lane       = lane_q;

endmodule

// File: doc/uart_rx_mem_writer.md
UART_RX_MEM_WRITER -- requirements
Module: uart_rx_mem_writer

Interface
REQ-001 Parameter DEPTH, default 40000, number of 32-bit words in the downstream on-chip memory.
REQ-002 Parameter ADDR_W, default 16, width of the word address.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  8  received byte from the UART RX stage.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block can accept a byte; a transfer occurs when in_valid and in_ready are both high.
REQ-008 flush  input  1  single-cycle pulse that commits a partially packed word.
REQ-009 clr  input  1  synchronous restart: pointer to 0, partial word discarded.
REQ-010 mem_address  output  ADDR_W  word address to the memory slave.
REQ-011 mem_writedata  output  32  packed word.
REQ-012 mem_byteenable  output  4  valid byte lanes of mem_writedata.
REQ-013 mem_chipselect  output  1  memory select; asserted only with mem_write.
REQ-014 mem_write  output  1  single-cycle write strobe.
REQ-015 wr_ptr  output  ADDR_W  next word address to be written, equal to the count of committed words mod DEPTH.
REQ-016 full  output  1  memory filled; meaningful only without the wrap feature.

Function
REQ-017 Bytes SHALL pack little-endian: the first byte of a word goes to lane 0 (bits 7:0) and the fourth to lane 3 (bits 31:24).
REQ-018 A 2-bit lane counter SHALL track the next lane and increment on every accepted byte.
REQ-019 On acceptance of the fourth byte, the packed word SHALL move to a write register and the lane counter SHALL return to 0 in the same cycle.
REQ-020 On the next cycle, mem_write and mem_chipselect SHALL pulse high for exactly one cycle, with mem_byteenable=4'b1111 and mem_address=wr_ptr; wr_ptr SHALL increment in that same cycle.
REQ-021 in_ready SHALL remain high during a write cycle, so back-to-back bytes are sustained at one byte per cycle with no stall.
REQ-022 A flush with lane>0 SHALL issue a write on the next cycle with byteenable 4'b0001, 4'b0011 or 4'b0111 for lane counts 1, 2 or 3, with unused lanes driven as 0, then reset the lane counter and increment wr_ptr.
REQ-023 A flush with lane=0 SHALL produce no write.
REQ-024 When flush and a byte acceptance occur in the same cycle, the byte SHALL be packed first; if that byte completes the word, the flush SHALL be a no-op.
REQ-025 clr SHALL have priority over flush and byte acceptance: in_ready is low while clr is high, the partial word and any pending write are discarded, and wr_ptr=0 and full=0 on the next cycle.
REQ-026 Address arithmetic SHALL be modulo DEPTH, not modulo 2^ADDR_W.
REQ-027 The FSM SHALL have two states, ACC and FULL; ACC goes to FULL only as defined in REQ-032; FULL goes to ACC only on clr.
REQ-028 In the FULL state: in_ready=0, flush is ignored, and mem_write=0.

Reset
REQ-029 While reset_n is low, all state SHALL clear immediately: in_ready=0, mem_write=0, mem_chipselect=0, mem_byteenable=0, mem_address=0, mem_writedata=0, wr_ptr=0, full=0, lane=0, state=ACC.
REQ-030 On the first clk edge after reset_n deasserts, in_ready SHALL be 1.
REQ-031 A reset that asserts in the middle of a word SHALL discard the partial word, and no write SHALL be emitted afterwards for it.

Configuration
REQ-032 Macro UART_RX_MEM_WRAP_EN selects the behaviour at the end of memory:
- Defined: after the write to address DEPTH-1, wr_ptr wraps to 0, full stays 0, and the FSM never enters FULL.
- Undefined: after the write to address DEPTH-1, wr_ptr stays at DEPTH-1, full=1, and the FSM enters FULL.

Verification
REQ-033 Reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after the 4th byte: mem_write=1, address=0, data=0x44332211, be=4'b1111; wr_ptr=1.
REQ-034 Eight continuous bytes 0x01..0x08 -> two writes to addresses 0 and 1 with data 0x04030201 and 0x08070605; in_ready never drops.
REQ-035 Bytes 0xAA,0xBB then a flush pulse -> write with data 0x0000BBAA, be=4'b0011; a second flush produces no write.
REQ-036 Force wr_ptr to DEPTH-1 and write one word -> with the macro: wr_ptr=0 and full=0; without the macro: full=1, in_ready=0, and further bytes are ignored until clr restores wr_ptr=0.
REQ-037 Three bytes, then clr together with in_valid -> no write, wr_ptr=0, lane=0; the next 4 bytes are written to address 0.
REQ-038 reset_n pulsed low between the 2nd and 3rd byte of a word -> all outputs go to 0 asynchronously, and no write is emitted for the partial word.
